// File: rtl/phase_gen_pkg.sv
// Shared types and widths for the dual-channel phase accumulator.
package wavegen_pkg;

  localparam int unsigned PHASE_W = 32;
  localparam int unsigned CYCLE_W = 16;

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [CYCLE_W-1:0] cycle_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  typedef struct packed {
    phase_t freq;
    phase_t ofs;
    cycle_t cycles;
  } chan_cfg_t;

endpackage

// File: rtl/phase_gen_if.sv
// Control/config/status bundle between the host side and phase_gen.
interface phase_gen_if;
  import wavegen_pkg::*;

  logic   SAMPLE_EN;
  logic   SYNC;

  logic   LOAD_A;
  phase_t FREQ_A;
  phase_t OFS_A;
  cycle_t CYCLES_A;
  logic   START_A;
  logic   STOP_A;

  logic   LOAD_B;
  phase_t FREQ_B;
  phase_t OFS_B;
  cycle_t CYCLES_B;
  logic   START_B;
  logic   STOP_B;

  phase_t PHASE_A;
  phase_t PHASE_B;
  logic   BUSY_A;
  logic   BUSY_B;
  logic   DONE_A;
  logic   DONE_B;

  modport master (
    output SAMPLE_EN, SYNC,
    output LOAD_A, FREQ_A, OFS_A, CYCLES_A, START_A, STOP_A,
    output LOAD_B, FREQ_B, OFS_B, CYCLES_B, START_B, STOP_B,
    input  PHASE_A, PHASE_B, BUSY_A, BUSY_B, DONE_A, DONE_B
  );

  modport slave (
    input  SAMPLE_EN, SYNC,
    input  LOAD_A, FREQ_A, OFS_A, CYCLES_A, START_A, STOP_A,
    input  LOAD_B, FREQ_B, OFS_B, CYCLES_B, START_B, STOP_B,
    output PHASE_A, PHASE_B, BUSY_A, BUSY_B, DONE_A, DONE_B
  );

endinterface

// File: rtl/phase_gen_channel.sv
// One phase-accumulator channel: shadow/active config, burst counter,
// IDLE/RUN control and registered phase output.
module phase_channel
  import wavegen_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   sample_en,
  input  logic   sync,
  input  logic   load,
  input  phase_t freq,
  input  phase_t ofs,
  input  cycle_t cycles,
  input  logic   start,
  input  logic   stop,
  output phase_t phase,
  output logic   busy,
  output logic   done
);

  chan_cfg_t   shadow_q;
  chan_cfg_t   active_q;
  phase_t      acc_q, acc_d;
  cycle_t      cnt_q, cnt_d;
  chan_state_t state_q, state_d;
  logic        done_q, done_d;
  phase_t      phase_q;

  phase_t         freq_eff;
  cycle_t         cycles_eff;
  logic [PHASE_W:0] sum;
  cycle_t         cnt_inc;
  logic           burst_end;

  // A sample tick both advances the accumulator and promotes the shadow,
  // so the tick itself runs on the promoted values; a LOAD on that same
  // edge only reaches the shadow and is picked up by the following tick.
  always_comb begin
    freq_eff   = sample_en ? shadow_q.freq   : active_q.freq;
    cycles_eff = sample_en ? shadow_q.cycles : active_q.cycles;
    sum        = {1'b0, acc_q} + {1'b0, freq_eff};
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + cycle_t'(1);
    burst_end  = sum[PHASE_W] && (cycles_eff != '0) && (cnt_inc >= cycles_eff);
  end

  // Next-state: STOP > START > SYNC > sample advance.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    done_d  = 1'b0;
    if (stop) begin
      acc_d   = '0;
      state_d = IDLE;
    end else if (start) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else if (sync) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_en && (state_q == RUN)) begin
      if (burst_end) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        acc_d = sum[PHASE_W-1:0];
        if (sum[PHASE_W]) begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  // Shadow capture on LOAD; promotion to active on START or sample tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (load) begin
        shadow_q <= '{freq: freq, ofs: ofs, cycles: cycles};
      end
      if (start || sample_en) begin
        active_q <= shadow_q;
      end
    end
  end

  // Accumulator, burst counter, FSM, DONE pulse and output phase word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      done_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      done_q  <= done_d;
      phase_q <= acc_q + active_q.ofs;
    end
  end

  assign phase = phase_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: rtl/phase_gen.sv
// Dual-channel NCO phase front end: two independent channels sharing the
// sample tick and the phase-align SYNC.
module phase_gen (
  input logic       CLK,
  input logic       RST_N,
  phase_gen_if.slave bus
);

  phase_channel u_chan_a (
    .clk       (CLK),
    .rst_n     (RST_N),
    .sample_en (bus.SAMPLE_EN),
    .sync      (bus.SYNC),
    .load      (bus.LOAD_A),
    .freq      (bus.FREQ_A),
    .ofs       (bus.OFS_A),
    .cycles    (bus.CYCLES_A),
    .start     (bus.START_A),
    .stop      (bus.STOP_A),
    .phase     (bus.PHASE_A),
    .busy      (bus.BUSY_A),
    .done      (bus.DONE_A)
  );

  phase_channel u_chan_b (
    .clk       (CLK),
    .rst_n     (RST_N),
    .sample_en (bus.SAMPLE_EN),
    .sync      (bus.SYNC),
    .load      (bus.LOAD_B),
    .freq      (bus.FREQ_B),
    .ofs       (bus.OFS_B),
    .cycles    (bus.CYCLES_B),
    .start     (bus.START_B),
    .stop      (bus.STOP_B),
    .phase     (bus.PHASE_B),
    .busy      (bus.BUSY_B),
    .done      (bus.DONE_B)
  );

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen with hand-computed expected values.
module tb_phase_gen;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  phase_gen_if bus ();

  phase_gen dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_a(input logic [31:0] f, input logic [31:0] o, input logic [15:0] c);
    bus.FREQ_A = f; bus.OFS_A = o; bus.CYCLES_A = c; bus.LOAD_A = 1'b1;
    tick();
    bus.LOAD_A = 1'b0;
  endtask

  task automatic load_b(input logic [31:0] f, input logic [31:0] o, input logic [15:0] c);
    bus.FREQ_B = f; bus.OFS_B = o; bus.CYCLES_B = c; bus.LOAD_B = 1'b1;
    tick();
    bus.LOAD_B = 1'b0;
  endtask

  task automatic stop_both();
    bus.SAMPLE_EN = 1'b0;
    bus.STOP_A = 1'b1; bus.STOP_B = 1'b1;
    tick();
    bus.STOP_A = 1'b0; bus.STOP_B = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] ea, eb;
    int unsigned ndone, done_at;

    RST_N = 1'b0;
    bus.SAMPLE_EN = 0; bus.SYNC = 0;
    bus.LOAD_A = 0; bus.FREQ_A = '0; bus.OFS_A = '0; bus.CYCLES_A = '0;
    bus.START_A = 0; bus.STOP_A = 0;
    bus.LOAD_B = 0; bus.FREQ_B = '0; bus.OFS_B = '0; bus.CYCLES_B = '0;
    bus.START_B = 0; bus.STOP_B = 0;
    tick(); tick();
    RST_N = 1'b1;
    tick();

    chk("rst_phase_a", bus.PHASE_A, 32'h0);
    chk("rst_phase_b", bus.PHASE_B, 32'h0);
    chk("rst_busy_a", {31'b0, bus.BUSY_A}, 32'h0);
    chk("rst_done_a", {31'b0, bus.DONE_A}, 32'h0);

    // 1: asynchronous reset mid-RUN
    load_a(32'h1000_0000, 32'h0, 16'd0);
    bus.START_A = 1; tick(); bus.START_A = 0;
    bus.SAMPLE_EN = 1;
    tick(); tick(); tick();
    chk("t1_pre_phase", bus.PHASE_A, 32'h2000_0000);
    chk("t1_pre_busy", {31'b0, bus.BUSY_A}, 32'h1);
    #2 RST_N = 1'b0;
    #1;
    chk("t1_async_phase", bus.PHASE_A, 32'h0);
    chk("t1_async_busy", {31'b0, bus.BUSY_A}, 32'h0);
    tick();
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_held_phase", bus.PHASE_A, 32'h0);
      chk("t1_held_busy", {31'b0, bus.BUSY_A}, 32'h0);
    end
    bus.SAMPLE_EN = 0;

    // 2: continuous quarter-turn steps
    load_a(32'h4000_0000, 32'h0, 16'd0);
    bus.START_A = 1; tick(); bus.START_A = 0;
    chk("t2_busy_start", {31'b0, bus.BUSY_A}, 32'h1);
    bus.SAMPLE_EN = 1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      ea = 32'(i) * 32'h4000_0000;
      chk("t2_phase", bus.PHASE_A, ea);
      chk("t2_busy", {31'b0, bus.BUSY_A}, 32'h1);
    end
    stop_both();

    // 3: two-cycle burst completes on the 8th tick
    load_a(32'h4000_0000, 32'h0, 16'd2);
    bus.START_A = 1; tick(); bus.START_A = 0;
    bus.SAMPLE_EN = 1;
    ndone = 0; done_at = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (bus.DONE_A) begin ndone++; done_at = i; end
      if (i == 7) chk("t3_busy_before", {31'b0, bus.BUSY_A}, 32'h1);
      if (i == 8) begin
        chk("t3_done_edge", {31'b0, bus.DONE_A}, 32'h1);
        chk("t3_busy_edge", {31'b0, bus.BUSY_A}, 32'h0);
      end
      if (i == 9) chk("t3_phase_after", bus.PHASE_A, 32'h0);
    end
    chk("t3_done_count", ndone, 32'd1);
    chk("t3_done_tick", done_at, 32'd8);
    stop_both();

    // 4: channels 180 degrees apart
    load_a(32'h4000_0000, 32'h0, 16'd0);
    load_b(32'h4000_0000, 32'h8000_0000, 16'd0);
    bus.START_A = 1; bus.START_B = 1; tick(); bus.START_A = 0; bus.START_B = 0;
    bus.SAMPLE_EN = 1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      tick();
      ea = 32'(i) * 32'h4000_0000;
      eb = ea + 32'h8000_0000;
      chk("t4_phase_a", bus.PHASE_A, ea);
      chk("t4_phase_b", bus.PHASE_B, eb);
    end
    stop_both();

    // 5: retune coincident with a sample tick
    load_a(32'h1000_0000, 32'h0, 16'd0);
    bus.START_A = 1; tick(); bus.START_A = 0;
    bus.SAMPLE_EN = 1;
    tick(); tick();
    bus.FREQ_A = 32'h2000_0000; bus.LOAD_A = 1;
    tick();
    bus.LOAD_A = 0;
    chk("t5_phase_t3", bus.PHASE_A, 32'h2000_0000);
    tick();
    chk("t5_phase_t4", bus.PHASE_A, 32'h3000_0000);
    tick();
    chk("t5_phase_t5", bus.PHASE_A, 32'h5000_0000);
    tick();
    chk("t5_phase_t6", bus.PHASE_A, 32'h7000_0000);
    stop_both();

    // 6: SYNC with sample tick, then STOP+START together
    load_a(32'h1000_0000, 32'h0100_0000, 16'd0);
    load_b(32'h3000_0000, 32'h4000_0000, 16'd0);
    bus.START_A = 1; bus.START_B = 1; tick(); bus.START_A = 0; bus.START_B = 0;
    bus.SAMPLE_EN = 1;
    tick(); tick(); tick();
    bus.SYNC = 1;
    tick();
    bus.SYNC = 0; bus.SAMPLE_EN = 0;
    chk("t6_sync_edge_a", bus.PHASE_A, 32'h3100_0000);
    chk("t6_sync_edge_b", bus.PHASE_B, 32'hD000_0000);
    tick();
    chk("t6_sync_ofs_a", bus.PHASE_A, 32'h0100_0000);
    chk("t6_sync_ofs_b", bus.PHASE_B, 32'h4000_0000);
    chk("t6_sync_busy_a", {31'b0, bus.BUSY_A}, 32'h1);
    chk("t6_sync_busy_b", {31'b0, bus.BUSY_B}, 32'h1);
    bus.SAMPLE_EN = 1;
    tick();
    bus.SAMPLE_EN = 0;
    tick();
    chk("t6_resume_a", bus.PHASE_A, 32'h1100_0000);
    chk("t6_resume_b", bus.PHASE_B, 32'h7000_0000);
    bus.STOP_A = 1; bus.START_A = 1;
    tick();
    bus.STOP_A = 0; bus.START_A = 0;
    chk("t6_stopstart_busy", {31'b0, bus.BUSY_A}, 32'h0);
    chk("t6_stopstart_done", {31'b0, bus.DONE_A}, 32'h0);
    tick();
    chk("t6_idle_phase_a", bus.PHASE_A, 32'h0100_0000);
    chk("t6_idle_done_a", {31'b0, bus.DONE_A}, 32'h0);
    chk("t6_b_still_busy", {31'b0, bus.BUSY_B}, 32'h1);
    stop_both();

    // Zero tuning word in burst mode: phase holds, burst never ends
    load_a(32'h0, 32'h0, 16'd1);
    bus.START_A = 1; tick(); bus.START_A = 0;
    bus.SAMPLE_EN = 1;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.DONE_A) ndone++;
    end
    chk("f0_done_count", ndone, 32'd0);
    chk("f0_busy", {31'b0, bus.BUSY_A}, 32'h1);
    chk("f0_phase", bus.PHASE_A, 32'h0);
    stop_both();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phase_gen.md
Name: phase_gen

Overview:
Dual-channel 32-bit phase accumulator (NCO front end) that produces the PHASE_A/PHASE_B words consumed by the sine LUT stage.
- Each channel advances by a frequency tuning word on every sample tick and adds a static phase offset.
- Each channel runs either continuously or for a programmed number of full cycles (burst mode).
- Configuration is double-buffered so retuning never produces a torn phase word.

Parameters:
PHASE_W, 32, accumulator/phase/tuning-word width (bit 31 = sine sign, bit 30 = quadrant direction)
CYCLE_W, 16, burst cycle-counter width

Ports:
CLK  in  1  system clock; single clock domain
RST_N  in  1  asynchronous active-low reset
SAMPLE_EN  in  1  sample-rate tick, one CLK wide; accumulators advance only on this
LOAD_A  in  1  pulse: capture FREQ_A/OFS_A/CYCLES_A into channel A shadow
FREQ_A  in  PHASE_W  channel A tuning word
OFS_A  in  PHASE_W  channel A phase offset
CYCLES_A  in  CYCLE_W  channel A burst length in full cycles; 0 = continuous
START_A  in  1  pulse: begin channel A output
STOP_A  in  1  pulse: abort channel A
LOAD_B, FREQ_B, OFS_B, CYCLES_B, START_B, STOP_B  in  as for A  channel B equivalents
SYNC  in  1  pulse: zero both accumulators together (phase-align A and B)
PHASE_A  out  PHASE_W  registered phase word, channel A
PHASE_B  out  PHASE_W  registered phase word, channel B
BUSY_A, BUSY_B  out  1  channel is in RUN
DONE_A, DONE_B  out  1  one-CLK pulse when a burst completes

Behaviour:
- Reset (async, RST_N=0): all accumulators, shadows, active registers, counters = 0; PHASE_x = 0; BUSY_x = 0; DONE_x = 0; FSM = IDLE.
- Shadow: LOAD_x captures FREQ/OFS/CYCLES on that CLK edge. Shadow copies into the active registers on the next SAMPLE_EN, or immediately on START_x.
- Per-channel FSM: IDLE, RUN.
  - IDLE -> RUN on START_x: acc = 0, cycle counter = 0, active <= shadow.
  - RUN -> IDLE on STOP_x: acc = 0, no DONE pulse.
  - RUN -> IDLE on burst completion: acc = 0, DONE_x pulses.
  - START_x while in RUN restarts: acc = 0, counter = 0.
- RUN, on SAMPLE_EN: {carry, acc} = acc + FREQ (PHASE_W+1-bit add; acc wraps modulo 2^PHASE_W). Carry increments the cycle counter.
- Burst completion: active CYCLES != 0 and the counter reaches CYCLES on this tick's carry. Same edge: acc = 0, FSM -> IDLE, DONE_x = 1 for exactly one CLK.
- Cycle counter saturates; it is ignored when CYCLES = 0.
- Output: PHASE_x = acc + active OFS (modulo 2^PHASE_W), registered. Latency is 1 CLK after the SAMPLE_EN edge that updated acc.
- In IDLE, PHASE_x = active OFS. The downstream output is then the static offset sample; 0 offset gives 0.
- SYNC sets both accumulators and cycle counters to 0 on the same edge; FSM states are unchanged.
- Priority, same edge: STOP > START > SYNC > SAMPLE_EN advance.
- LOAD with SAMPLE_EN on the same edge: the newly loaded value is applied on the following SAMPLE_EN, never half-applied.
- FREQ = 0 in RUN: phase holds; a burst never completes (STOP required).
- FREQ >= 2^(PHASE_W-1) is legal: one carry per wrap, aliasing is the user's concern.
- BUSY_x = (state == RUN), registered, same edge as the transition.

Decomposition:
- Package wavegen_pkg:
  - PHASE_W and CYCLE_W constants
  - phase_t and cycle_t typedefs
  - chan_state_t enum {IDLE, RUN}
  - chan_cfg_t struct {freq, ofs, cycles}
- Sub-module phase_channel: one accumulator, shadow/active config, cycle counter, FSM, output register. Instantiated twice.
- phase_gen contains only the two instances plus shared SAMPLE_EN/SYNC fan-out.

Test Plan:
1. Reset mid-RUN (FREQ_A=0x1000_0000, assert RST_N=0 between edges) -> PHASE_A=0, BUSY_A=0 immediately, asynchronously; held after release until START_A.
2. LOAD_A FREQ=0x4000_0000 OFS=0, CYCLES=0, START_A, SAMPLE_EN every CLK -> PHASE_A sequence 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0000_0000, repeating; BUSY_A stays 1.
3. CYCLES_A=2, FREQ=0x4000_0000, START_A -> DONE_A pulses exactly once on the 8th SAMPLE_EN; same edge BUSY_A=0, acc=0; PHASE_A=0 next CLK.
4. Channel B FREQ=0x4000_0000 OFS=0x8000_0000, START_A and START_B same edge with A OFS=0 -> PHASE_B = PHASE_A + 0x8000_0000 on every sample (180° apart).
5. Running A at FREQ=0x1000_0000, LOAD_A FREQ=0x2000_0000 on the edge of a SAMPLE_EN -> that tick still uses 0x1000_0000; following ticks step by 0x2000_0000.
6. SYNC and SAMPLE_EN on the same edge while both channels run -> both acc = 0 and PHASE_x = OFS_x next CLK. STOP_A with START_A on the same edge -> IDLE, no DONE_A.
